// File: rtl/pixel_plot_writer_pkg.sv
// Shared constants and types for the pixel plot writer: frame geometry,
// derived frame-buffer address width, FIFO entry layout and address helper.
package pixel_plot_writer_pkg;

  localparam int XRES      = 160;
  localparam int YRES      = 120;
  localparam int COLW      = 3;
  localparam int UBYTE_W   = 8;
  localparam int NPIX      = XRES * YRES;
  localparam int ADDRW     = $clog2(NPIX);
  localparam int DEPTH     = 8;
  localparam int LVLW      = $clog2(DEPTH) + 1;

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(NPIX - 1);

  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [COLW-1:0]  color;
  } pix_entry_t;

  localparam int ENTRY_W = $bits(pix_entry_t);

  // Linear address y*XRES + x, kept to ADDRW bits so the multiplier never widens.
  function automatic logic [ADDRW-1:0] pixel_addr(input logic [UBYTE_W-1:0] x,
                                                  input logic [UBYTE_W-1:0] y);
    return ADDRW'(y) * ADDRW'(XRES) + ADDRW'(x);
  endfunction

endpackage

// File: rtl/pixel_plot_writer_if.sv
// Pixel stream in and frame-buffer write port out, bundled for the writer.
interface pixel_plot_writer_if;
  import pixel_plot_writer_pkg::*;

  // Renderer side: a pixel is offered whenever plot=1 (no back-pressure, drops
  // are reported via flags). RAM side: memWe is a single-cycle write strobe that
  // is only issued in the cycle after memReady was seen high with data queued.
  logic               plot;
  logic [UBYTE_W-1:0] x;
  logic [UBYTE_W-1:0] y;
  logic [COLW-1:0]    color;
  logic               memReady;
  logic               memWe;
  logic [ADDRW-1:0]   memAddr;
  logic [COLW-1:0]    memData;

  modport master (output plot, x, y, color, memReady,
                  input  memWe, memAddr, memData);
  modport slave  (input  plot, x, y, color, memReady,
                  output memWe, memAddr, memData);

endinterface

// File: rtl/pixel_plot_writer_sync_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide, even when
// full, because the slot being vacated is the one the write pointer reuses.
module pixel_plot_writer_sync_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   LVL_ONE = (PW+1)'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   level_q;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (level_q == (PW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/pixel_plot_writer.sv
// Buffers renderer pixels, converts (x, y) to a linear address and drains them
// into the frame-buffer RAM, reporting frame completion, drops and range errors.
module pixel_plot_writer
    import pixel_plot_writer_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    pixel_plot_writer_if.slave    bus,
    input  logic                  enable_i,
    input  logic                  clearFlags_i,
    output logic                  frameDone_o,
    output logic                  overflow_o,
    output logic                  rangeErr_o,
    output logic [LVLW-1:0]       fifoLevel_o
);
    logic             in_range, push, pop, full, empty;
    logic             drop_range, drop_full;
    pix_entry_t       wentry, head;
    logic [ENTRY_W-1:0] head_raw;

    logic             mem_we_q, frame_done_q;
    logic [ADDRW-1:0] mem_addr_q;
    logic [COLW-1:0]  mem_data_q;
    logic             overflow_q, overflow_d;
    logic             range_err_q, range_err_d;

    assign in_range   = (bus.x < UBYTE_W'(XRES)) && (bus.y < UBYTE_W'(YRES));
    assign pop        = enable_i && !empty && bus.memReady;
    assign push       = enable_i && bus.plot && in_range && (!full || pop);
    assign drop_range = enable_i && bus.plot && !in_range;
    assign drop_full  = enable_i && bus.plot && in_range && full && !pop;

    assign wentry.addr  = pixel_addr(bus.x, bus.y);
    assign wentry.color = bus.color;
    assign head         = pix_entry_t'(head_raw);

    pixel_plot_writer_sync_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (head_raw),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifoLevel_o)
    );

    // A new error in the same cycle as clearFlags wins; enable=0 freezes flags.
    always_comb begin
        overflow_d  = overflow_q;
        range_err_d = range_err_q;
        if (enable_i) begin
            if (clearFlags_i) begin
                overflow_d  = 1'b0;
                range_err_d = 1'b0;
            end
            if (drop_full)  overflow_d  = 1'b1;
            if (drop_range) range_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            overflow_q   <= 1'b0;
            range_err_q  <= 1'b0;
        end else begin
            mem_we_q     <= pop;
            frame_done_q <= pop && (head.addr == LAST_ADDR);
            if (pop) begin
                mem_addr_q <= head.addr;
                mem_data_q <= head.color;
            end
            overflow_q   <= overflow_d;
            range_err_q  <= range_err_d;
        end
    end

    assign bus.memWe   = mem_we_q;
    assign bus.memAddr = mem_addr_q;
    assign bus.memData = mem_data_q;
    assign frameDone_o = frame_done_q;
    assign overflow_o  = overflow_q;
    assign rangeErr_o  = range_err_q;

endmodule

// File: tb/tb_pixel_plot_writer.sv
// Self-checking bench for pixel_plot_writer: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_pixel_plot_writer;
  import pixel_plot_writer_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  logic enable;
  logic clear_flags;
  logic frame_done;
  logic overflow;
  logic range_err;
  logic [LVLW-1:0] fifo_level;

  pixel_plot_writer_if bus();

  pixel_plot_writer dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus),
    .enable_i     (enable),
    .clearFlags_i (clear_flags),
    .frameDone_o  (frame_done),
    .overflow_o   (overflow),
    .rangeErr_o   (range_err),
    .fifoLevel_o  (fifo_level)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // reference model state: queue of {address, colour}
  logic [ADDRW+COLW-1:0] exp_q[$];
  int   exp_we, exp_addr, exp_data, exp_fd, exp_ovf, exp_rerr;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_update(input logic p, input int xx, input int yy, input int c,
                              input logic mr, input logic en, input logic clr, input logic rn);
    bit in_r, do_pop, do_push, is_full;
    logic [ADDRW+COLW-1:0] head;
    if (!rn) begin
      exp_q.delete();
      exp_we = 0; exp_addr = 0; exp_data = 0; exp_fd = 0; exp_ovf = 0; exp_rerr = 0;
      return;
    end
    in_r    = (xx < XRES) && (yy < YRES);
    is_full = (exp_q.size() == DEPTH);
    do_pop  = en && (exp_q.size() > 0) && mr;
    do_push = en && p && in_r && (!is_full || do_pop);
    if (do_pop) begin
      head     = exp_q.pop_front();
      exp_we   = 1;
      exp_addr = int'(head[ADDRW+COLW-1:COLW]);
      exp_data = int'(head[COLW-1:0]);
      exp_fd   = (exp_addr == XRES * YRES - 1) ? 1 : 0;
    end else begin
      exp_we = 0;
      exp_fd = 0;
    end
    if (do_push) exp_q.push_back({ADDRW'(yy * XRES + xx), COLW'(c)});
    if (en) begin
      if (clr) begin exp_ovf = 0; exp_rerr = 0; end
      if (p && !in_r) exp_rerr = 1;
      if (p && in_r && is_full && !do_pop) exp_ovf = 1;
    end
  endtask

  // driver: apply inputs away from the edge, advance one clock, update the model, compare
  task automatic step(input logic p, input int xx, input int yy, input int c,
                      input logic mr, input logic en, input logic clr, input logic rn);
    @(negedge clk);
    bus.plot     = p;
    bus.x        = 8'(xx);
    bus.y        = 8'(yy);
    bus.color    = COLW'(c);
    bus.memReady = mr;
    enable       = en;
    clear_flags  = clr;
    resetn       = rn;
    @(posedge clk);
    model_update(p, xx, yy, c, mr, en, clr, rn);
    #1;
    check("memWe",     32'(bus.memWe),   32'(exp_we));
    check("frameDone", 32'(frame_done),  32'(exp_fd));
    check("overflow",  32'(overflow),    32'(exp_ovf));
    check("rangeErr",  32'(range_err),   32'(exp_rerr));
    check("fifoLevel", 32'(fifo_level),  32'(exp_q.size()));
    if (exp_we != 0) begin
      check("memAddr", 32'(bus.memAddr), 32'(exp_addr));
      check("memData", 32'(bus.memData), 32'(exp_data));
    end
  endtask

  task automatic idle(input int n, input logic mr);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, mr, 1'b1, 1'b0, 1'b1);
  endtask

  int n_we, n_fd, fd_addr;
  int drained[$];

  initial begin
    bus.plot = 1'b0; bus.x = '0; bus.y = '0; bus.color = '0; bus.memReady = 1'b0;
    enable = 1'b0; clear_flags = 1'b0; resetn = 1'b0;

    // 1: reset values and first-pixel latency
    for (int i = 0; i < 3; i++) step(1'b1, 3, 2, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    check("reset_memAddr", 32'(bus.memAddr), 32'd0);
    step(1'b1, 3, 2, 5, 1'b1, 1'b1, 1'b0, 1'b1);
    check("lat_we_early", 32'(bus.memWe), 32'd0);
    step(1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("lat_we",   32'(bus.memWe),   32'd1);
    check("lat_addr", 32'(bus.memAddr), 32'd323);
    check("lat_data", 32'(bus.memData), 32'd5);
    idle(2, 1'b1);

    // 2: full frame in raster order
    n_we = 0; n_fd = 0; fd_addr = -1;
    for (int i = 0; i < XRES * YRES + 3; i++) begin
      if (i < XRES * YRES)
        step(1'b1, i % XRES, i / XRES, $urandom_range(0, 7), 1'b1, 1'b1, 1'b0, 1'b1);
      else
        idle(1, 1'b1);
      if (bus.memWe) n_we++;
      if (frame_done) begin n_fd++; fd_addr = int'(bus.memAddr); end
    end
    check("frame_writes",  32'(n_we), 32'd19200);
    check("frame_done_n",  32'(n_fd), 32'd1);
    check("frame_done_at", 32'(fd_addr), 32'd19199);
    check("frame_ovf",     32'(overflow), 32'd0);

    // 3: stalled RAM overflows after eight pixels, drain keeps order
    for (int i = 0; i < 10; i++) step(1'b1, 10 + i, 1, i % 8, 1'b0, 1'b1, 1'b0, 1'b1);
    check("stall_level", 32'(fifo_level), 32'd8);
    check("stall_ovf",   32'(overflow),   32'd1);
    drained.delete();
    for (int i = 0; i < 10; i++) begin
      idle(1, 1'b1);
      if (bus.memWe) drained.push_back(int'(bus.memAddr));
    end
    check("drain_count", 32'(drained.size()), 32'd8);
    for (int i = 0; i < drained.size(); i++) check("drain_order", 32'(drained[i]), 32'(170 + i));

    // 4: push and pop together while full
    step(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, i, 5, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 9, 5, 2, 1'b1, 1'b1, 1'b0, 1'b1);
    check("full_pp_level", 32'(fifo_level), 32'd8);
    check("full_pp_ovf",   32'(overflow),   32'd0);
    idle(10, 1'b1);

    // 5: out-of-range pixels, then clear
    step(1'b1, 160, 0, 3, 1'b1, 1'b1, 1'b0, 1'b1);
    check("range_x", 32'(range_err), 32'd1);
    step(1'b1, 0, 120, 3, 1'b1, 1'b1, 1'b0, 1'b1);
    check("range_level", 32'(fifo_level), 32'd0);
    step(1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("range_clear", 32'(range_err), 32'd0);

    // 6: reset with pixels queued
    for (int i = 0; i < 5; i++) step(1'b1, i, 7, 4, 1'b0, 1'b1, 1'b0, 1'b1);
    check("pre_rst_level", 32'(fifo_level), 32'd5);
    step(1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_level", 32'(fifo_level), 32'd0);
    step(1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_no_we", 32'(bus.memWe), 32'd0);

    // 7: randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic en_r;
      en_r = ($urandom_range(0, 9) != 0);
      step($urandom_range(0, 2) != 0, $urandom_range(0, 165), $urandom_range(0, 123),
           $urandom_range(0, 7), $urandom_range(0, 3) != 0, en_r,
           en_r && ($urandom_range(0, 19) == 0), $urandom_range(0, 299) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_plot_writer.md
Name: pixel_plot_writer

Overview:
Downstream stage of the game pixel renderer. Accepts the renderer's (x, y, color, plot) pixel stream, buffers it in a small FIFO, converts coordinates to a linear frame-buffer address, and drains writes into the frame-buffer RAM port under a memReady handshake. Reports frame completion, overflow and range errors to the game controller.

Parameters:
XRES, 160, pixels per row; legal x range is 0..XRES-1.
YRES, 120, rows per frame; legal y range is 0..YRES-1.
COLW, 3, colour width in bits.
ADDRW, 15, frame-buffer address width; must satisfy 2^ADDRW >= XRES*YRES.
DEPTH, 8, FIFO entries; power of two.

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
enable  in  1  global enable; when low, no push and no pop occur
plot  in  1  renderer pixel-valid strobe
x  in  8  pixel column
y  in  8  pixel row
color  in  COLW  pixel colour
clearFlags  in  1  synchronous clear of the sticky flags
memReady  in  1  RAM can accept a write this cycle
memWe  out  1  RAM write strobe, registered
memAddr  out  ADDRW  RAM address, registered
memData  out  COLW  RAM data, registered
frameDone  out  1  one-cycle pulse coincident with the memWe of pixel (XRES-1, YRES-1)
overflow  out  1  sticky flag: a pixel was dropped because the FIFO was full
rangeErr  out  1  sticky flag: a pixel was dropped because it was out of range
fifoLevel  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (resetn=0 at a clk edge) takes priority over all other activity. All outputs go to 0, the FIFO is emptied, and the pointers clear. Reset mid-drain discards any queued pixels, and no memWe is issued on the following cycle.
- Push condition: enable && plot && inRange && (!full || popThisCycle). The stored entry is {addr, color}, where addr = y*XRES + x. Compute it with ADDRW-bit unsigned arithmetic before storage; do not use a multiplier wider than ADDRW.
- inRange = (x < XRES) && (y < YRES). When plot && enable && !inRange: the pixel is dropped and rangeErr is set.
- When plot && enable && inRange && full && !popThisCycle: the pixel is dropped and overflow is set.
- popThisCycle = enable && !empty && memReady.
- On a pop, the next edge registers memAddr and memData from the FIFO head, sets memWe=1, and sets frameDone=1 if the head address equals XRES*YRES-1.
- When there is no pop: memWe=0 and frameDone=0. memAddr and memData hold their last values.
- Latency: a pixel pushed at edge N into an empty FIFO, with memReady held high, appears with memWe=1 in the cycle after edge N+1 (two-clock latency).
- Throughput: one pixel per clock when memReady is held high.
- Simultaneous push and pop: fifoLevel is unchanged; this is legal even when the FIFO is full.
- Ordering: strict FIFO order. Pointers wrap modulo DEPTH.
- Sticky flags clear only on reset or clearFlags=1. If clearFlags and a new error occur in the same cycle, the set wins.
- enable=0 freezes the FIFO contents, pointers and flags. memWe and frameDone are forced to 0 on the next edge.
- fifoLevel ranges over 0..DEPTH and updates on the same edge as each push or pop.

Decomposition:
- Shared constants package: XRES, YRES, COLW and the ubyte width (8). The frame-buffer address width and the last-pixel address XRES*YRES-1 derive from these.
- One natural sub-module: sync_fifo. It is parameterised by width and depth and provides push, pop, full, empty and level, with simultaneous push and pop allowed when full.
- Keep the address computation, range check and flag logic in the top module.

Test Plan:
1. Reset, then plot (x=3, y=2, color=5) with memReady=1 -> after 2 clocks: memWe=1, memAddr=323, memData=5. All outputs are 0 while resetn=0.
2. Stream a full frame, one pixel per clock in raster order, with memReady=1 -> 19200 memWe pulses in order, frameDone high only with memAddr=19199, overflow=0.
3. memReady=0 while plotting 10 pixels -> fifoLevel reaches 8 and overflow=1. On memReady=1, exactly the first 8 pixels drain, in order.
4. FIFO full, with plot and memReady both high in the same cycle -> push accepted, fifoLevel stays 8, overflow stays 0.
5. plot with x=160 or y=120 -> nothing enqueued and rangeErr=1. Then clearFlags=1 -> rangeErr=0 on the next clock.
6. Assert resetn=0 with 5 pixels queued -> no memWe afterwards, and fifoLevel=0.
